// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
//   state_e : top-level operating mode (RUN, HALT, ADJ)
//   bcd_t   : one BCD digit
//   ONES_MAX / TENS_MAX : digit limits giving the 00..59 range of a field
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ADJ  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t ONES_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;

endpackage : stopwatch_pkg

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter over 00..59, used once for seconds and once for minutes.
// Ports:
//   FasterClock, ResetN : clock and async active-low reset
//   Inc      : advance by one this cycle (59 wraps to 00)
//   Clear    : synchronous clear to 00, wins over Inc
//   Tens     : tens digit, 0..5
//   Ones     : ones digit, 0..9
//   CarryOut : combinational, high when Inc is asserted while at 59
module bcd_mod60_counter
  import stopwatch_pkg::*;
(
  input  logic FasterClock,
  input  logic ResetN,
  input  logic Inc,
  input  logic Clear,
  output bcd_t Tens,
  output bcd_t Ones,
  output logic CarryOut
);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max;

  assign at_max   = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
  assign CarryOut = Inc && at_max;

  // NOTE: every always_comb output gets a hold default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (Clear) begin
      tens_d = '0;
      ones_d = '0;
    end else if (Inc) begin
      if (ones_q == ONES_MAX) begin
        ones_d = '0;
        tens_d = (tens_q == TENS_MAX) ? bcd_t'(0) : bcd_t'(tens_q + 4'd1);
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge FasterClock or negedge ResetN) begin
    if (!ResetN) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign Tens = tens_q;
  assign Ones = ones_q;

endmodule : bcd_mod60_counter

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: mm:ss BCD counter with pause toggle and
// per-field adjust mode. Sits behind the button debouncer and feeds the
// seven-segment driver.
// Ports:
//   FasterClock, ResetN : system clock, async active-low reset
//   OneHzEn   : 1 Hz single-cycle pulse, counts in RUN
//   TwoHzEn   : 2 Hz single-cycle pulse, adjust increment and blink in ADJ
//   PauseIn   : debounced pause level; each rising edge toggles Paused
//   AdjustIn  : debounced adjust switch, 1 = adjust mode
//   SelectIn  : field to adjust, 0 = minutes, 1 = seconds
//   MinTens, MinOnes, SecTens, SecOnes : BCD display digits
//   Paused      : pause flag
//   AdjustBlink : blink phase for the field under adjustment
module stopwatch_counter
  import stopwatch_pkg::*;
(
  input  logic FasterClock,
  input  logic ResetN,
  input  logic OneHzEn,
  input  logic TwoHzEn,
  input  logic PauseIn,
  input  logic AdjustIn,
  input  logic SelectIn,
  output bcd_t MinTens,
  output bcd_t MinOnes,
  output bcd_t SecTens,
  output bcd_t SecOnes,
  output logic Paused,
  output logic AdjustBlink
);

  state_e state_q, state_d;
  logic   pause_prev_q, pause_prev_d;
  logic   paused_q, paused_d;
  logic   blink_q, blink_d;
  logic   pause_edge;
  logic   sec_inc, sec_carry, min_inc;

  assign pause_edge = PauseIn && !pause_prev_q;

  // Digit action follows the registered state, so a pulse arriving together
  // with a mode change is handled by the mode being left.
  assign sec_inc = ((state_q == RUN) && OneHzEn) ||
                   ((state_q == ADJ) && TwoHzEn && SelectIn);
  // sec_carry can also fire in ADJ at 59 seconds; only RUN chains it on.
  assign min_inc = ((state_q == RUN) && sec_carry) ||
                   ((state_q == ADJ) && TwoHzEn && !SelectIn);

  bcd_mod60_counter u_sec (
    .FasterClock (FasterClock),
    .ResetN      (ResetN),
    .Inc         (sec_inc),
    .Clear       (1'b0),
    .Tens        (SecTens),
    .Ones        (SecOnes),
    .CarryOut    (sec_carry)
  );

  bcd_mod60_counter u_min (
    .FasterClock (FasterClock),
    .ResetN      (ResetN),
    .Inc         (min_inc),
    .Clear       (1'b0),
    .Tens        (MinTens),
    .Ones        (MinOnes),
    .CarryOut    ()
  );

  always_comb begin
    pause_prev_d = PauseIn;
    paused_d     = paused_q ^ pause_edge;
    state_d      = state_q;
    blink_d      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (AdjustIn)        state_d = ADJ;
        else if (pause_edge) state_d = HALT;
      end
      HALT: begin
        if (AdjustIn)        state_d = ADJ;
        else if (pause_edge) state_d = RUN;
      end
      ADJ: begin
        // Leaving ADJ lands on the mode matching the updated pause flag.
        if (!AdjustIn) state_d = paused_d ? HALT : RUN;
        else           blink_d = blink_q ^ TwoHzEn;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: ResetN is asynchronous, so reset values appear immediately rather
  // than waiting for the next clock edge.
  always_ff @(posedge FasterClock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= RUN;
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_prev_q <= pause_prev_d;
      paused_q     <= paused_d;
      blink_q      <= blink_d;
    end
  end

  assign Paused      = paused_q;
  assign AdjustBlink = blink_q;

endmodule : stopwatch_counter

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against a
// behavioural model that keeps time as integer minutes/seconds.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       one_hz, two_hz, pause_in, adjust_in, select_in;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       paused, adjust_blink;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: time as integers, mode as two flags.
  int   m_min, m_sec;
  logic m_paused, m_adj, m_blink, m_prev_pause;

  stopwatch_counter dut (
    .FasterClock (clk),
    .ResetN      (rst_n),
    .OneHzEn     (one_hz),
    .TwoHzEn     (two_hz),
    .PauseIn     (pause_in),
    .AdjustIn    (adjust_in),
    .SelectIn    (select_in),
    .MinTens     (min_tens),
    .MinOnes     (min_ones),
    .SecTens     (sec_tens),
    .SecOnes     (sec_ones),
    .Paused      (paused),
    .AdjustBlink (adjust_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [17:0] model_vec();
    logic [3:0] mt, mo, st, so;
    mt = 4'(m_min / 10);
    mo = 4'(m_min % 10);
    st = 4'(m_sec / 10);
    so = 4'(m_sec % 10);
    return {mt, mo, st, so, m_paused, m_blink};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0;
    m_paused = 1'b0; m_adj = 1'b0; m_blink = 1'b0; m_prev_pause = 1'b0;
  endtask

  // One clock edge of the specified behaviour, given the sampled inputs.
  // Stopwatch is halted exactly when outside adjust with the pause flag set.
  task automatic model_step(input logic o, t, p, a, s);
    logic edge_seen, was_adj;
    int   total;
    edge_seen    = p && !m_prev_pause;
    m_prev_pause = p;
    was_adj      = m_adj;
    if (was_adj) begin
      if (t) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else   m_min = (m_min + 1) % 60;
      end
    end else if (!m_paused && o) begin
      total = (m_min * 60 + m_sec + 1) % 3600;
      m_min = total / 60;
      m_sec = total % 60;
    end
    m_paused = m_paused ^ edge_seen;
    m_blink  = (was_adj && a) ? (m_blink ^ t) : 1'b0;
    m_adj    = a;
  endtask

  // Inputs change at posedge+1; the next edge samples them.
  task automatic cyc(input logic o, t, p, a, s);
    one_hz = o; two_hz = t; pause_in = p; adjust_in = a; select_in = s;
    @(posedge clk);
    #1;
    model_step(o, t, p, a, s);
  endtask

  task automatic do_reset();
    one_hz = 0; two_hz = 0; pause_in = 0; adjust_in = 0; select_in = 0;
    #1 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n)
      check("cycle", 32'({min_tens, min_ones, sec_tens, sec_ones, paused, adjust_blink}),
            32'(model_vec()));
  end

  initial begin
    rst_n = 1'b0;
    one_hz = 0; two_hz = 0; pause_in = 0; adjust_in = 0; select_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_digits", 32'(disp()), 32'h0000);
    check("reset_flags", 32'({paused, adjust_blink}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three 1 Hz pulses from reset.
    repeat (3) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    check("count3", 32'(disp()), 32'h0003);
    check("count3_paused", 32'(paused), 32'h0);

    // Preload 59:58 through adjust, then roll over in RUN.
    cyc(0, 0, 0, 1, 0);
    repeat (59) begin cyc(0, 1, 0, 1, 0); cyc(0, 0, 0, 1, 0); end
    repeat (55) begin cyc(0, 1, 0, 1, 1); cyc(0, 0, 0, 1, 1); end
    check("preload", 32'(disp()), 32'h5958);
    cyc(0, 0, 0, 0, 0);
    check("exit_adj_blink", 32'(adjust_blink), 32'h0);
    cyc(1, 0, 0, 0, 0);
    check("roll_5959", 32'(disp()), 32'h5959);
    cyc(1, 0, 0, 0, 0);
    check("roll_0000", 32'(disp()), 32'h0000);

    // Pause while held high, pulses ignored, second press resumes.
    repeat (5) begin cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
    check("at_0005", 32'(disp()), 32'h0005);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(logic'(i % 3 == 0), 0, 1, 0, 0);
    check("halt_paused", 32'(paused), 32'h1);
    check("halt_hold", 32'(disp()), 32'h0005);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("resume_paused", 32'(paused), 32'h0);
    cyc(1, 0, 1, 0, 0);
    check("resume_0006", 32'(disp()), 32'h0006);
    cyc(0, 0, 0, 0, 0);

    // Adjust from 00:00: minutes wrap once, then seconds; 1 Hz ignored.
    do_reset();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    check("blink_first", 32'(adjust_blink), 32'h1);
    repeat (60) begin cyc(0, 1, 0, 1, 0); cyc(1, 0, 0, 1, 0); end
    check("adj_min_wrap", 32'(disp()), 32'h0100);
    check("blink_odd", 32'(adjust_blink), 32'h1);
    repeat (3) begin cyc(1, 1, 0, 1, 1); cyc(0, 0, 0, 1, 1); end
    check("adj_sec", 32'(disp()), 32'h0103);
    check("blink_even", 32'(adjust_blink), 32'h0);
    cyc(0, 0, 0, 0, 0);

    // Simultaneous events.
    do_reset();
    repeat (7) begin cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
    cyc(1, 0, 1, 0, 0);
    check("sim_pause_count", 32'(disp()), 32'h0008);
    check("sim_pause_flag", 32'(paused), 32'h1);
    cyc(1, 0, 1, 0, 0);
    check("sim_halted", 32'(disp()), 32'h0008);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    check("sim_adj_count", 32'(disp()), 32'h0009);
    cyc(1, 0, 0, 1, 0);
    check("sim_adj_ignore", 32'(disp()), 32'h0009);

    // Async reset mid-adjust at 12:34.
    do_reset();
    cyc(0, 0, 0, 1, 0);
    repeat (12) begin cyc(0, 1, 0, 1, 0); cyc(0, 0, 0, 1, 0); end
    repeat (34) begin cyc(0, 1, 0, 1, 1); cyc(0, 0, 0, 1, 1); end
    cyc(0, 1, 1, 1, 1);
    check("pre_reset", 32'(disp()), 32'h1235);
    one_hz = 0; two_hz = 0; pause_in = 0; adjust_in = 0; select_in = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_digits", 32'(disp()), 32'h0000);
    check("async_flags", 32'({paused, adjust_blink}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("async_run", 32'(disp()), 32'h0001);

    // Randomized run; levels are held several cycles to resemble buttons.
    begin
      logic p, a, s;
      p = 0; a = 0; s = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(7) == 0)  p = ~p;
        if ($urandom_range(24) == 0) a = ~a;
        if ($urandom_range(9) == 0)  s = ~s;
        cyc(logic'($urandom_range(2) == 0), logic'($urandom_range(2) == 0), p, a, s);
      end
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stopwatch_counter

// File: doc/stopwatch_counter.md
# stopwatch_counter

Stopwatch timekeeping core that sits directly downstream of the button debouncer. It consumes the debounced PauseIn/AdjustIn/SelectIn levels and the 1 Hz / 2 Hz enable pulses, and runs a mm:ss BCD counter. It supports pause toggling and per-field adjust mode. Its digit outputs feed the seven-segment display driver.

## Interface
Parameters:
- none; the 0–59 range is fixed by package constants.

Ports:
- FasterClock  input  1  system clock; all state updates on its rising edge
- ResetN  input  1  reset, asynchronous, active-low
- OneHzEn  input  1  single-cycle pulse, 1 Hz, run-mode count enable
- TwoHzEn  input  1  single-cycle pulse, 2 Hz, adjust-mode increment and blink enable
- PauseIn  input  1  debounced pause button level (1 = pressed)
- AdjustIn  input  1  debounced adjust switch (1 = adjust mode)
- SelectIn  input  1  debounced select switch (0 = minutes, 1 = seconds)
- MinTens  output  4  minutes tens digit, BCD 0–5
- MinOnes  output  4  minutes ones digit, BCD 0–9
- SecTens  output  4  seconds tens digit, BCD 0–5
- SecOnes  output  4  seconds ones digit, BCD 0–9
- Paused  output  1  pause flag
- AdjustBlink  output  1  blink phase for the field being adjusted

## Operation
- Pause edge detect:
  - PausePrev register tracks PauseIn.
  - PauseEdge = PauseIn & ~PausePrev.
  - PauseEdge toggles Paused in every state, including ADJ. Holding PauseIn high produces exactly one toggle.
- FSM states: RUN, HALT, ADJ.
  - RUN → ADJ when AdjustIn=1. RUN → HALT on PauseEdge.
  - HALT → ADJ when AdjustIn=1. HALT → RUN on PauseEdge.
  - ADJ → HALT when AdjustIn=0 and Paused (post-update) = 1. ADJ → RUN when AdjustIn=0 and Paused (post-update) = 0.
  - AdjustIn=1 has priority over PauseEdge for the state transition; the flag still toggles.
- RUN, on OneHzEn:
  - SecOnes increments; 9 → 0 with carry into SecTens.
  - SecTens 5 → 0 with carry into MinOnes; MinOnes 9 → 0 with carry into MinTens; MinTens 5 → 0.
  - 59:59 wraps to 00:00. There is no overflow flag.
- HALT: digits hold. OneHzEn and TwoHzEn are ignored.
- ADJ, on TwoHzEn:
  - The field chosen by SelectIn increments mod 60 (59 → 00). The other field holds.
  - There is no carry between fields. OneHzEn is ignored.
  - SelectIn is sampled in the same cycle as TwoHzEn; a change in SelectIn affects the next increment only.
- AdjustBlink:
  - Toggles on each TwoHzEn while in ADJ.
  - Forced to 0 in the cycle the FSM leaves ADJ, and held at 0 in RUN and HALT.
- Simultaneous events:
  - Digit action is decided by the current registered state, not the next state.
  - Example: OneHzEn in the same cycle as a PauseEdge in RUN still counts; HALT takes effect the next cycle.
  - OneHzEn and TwoHzEn together in ADJ: only the adjust increment applies.
- Reset mid-operation: ResetN low immediately forces the reset values regardless of state or pending pulses.

## Timing
- Reset values:
  - all four digits 0
  - Paused 0
  - AdjustBlink 0
  - PausePrev 0
  - state RUN
- All outputs are registered. There is no combinational input-to-output path.
- Digit latency: an outputs change on the rising edge that samples OneHzEn or TwoHzEn high, so the new value is visible one cycle after the pulse is presented.
- Paused flips on the rising edge that first samples PauseIn=1 after a 0.
- State change takes effect one edge after AdjustIn or PauseEdge is sampled.
- Input pulses are assumed exactly one FasterClock cycle wide. A wider pulse counts once per cycle it is high.

## Structure
- Shared package stopwatch_pkg:
  - state enum (RUN, HALT, ADJ)
  - BCD limit constants (ONES_MAX=9, TENS_MAX=5)
  - 4-bit BCD digit typedef
- Sub-module bcd_mod60_counter:
  - inputs: Inc, Clear
  - outputs: Tens, Ones, CarryOut (combinational, high when Inc is asserted at 59)
  - instantiated twice: seconds instance with CarryOut feeding the minutes instance's Inc in RUN; minutes instance driven directly in ADJ.
- FSM, pause edge detect and blink logic live in stopwatch_counter.

## Test plan
- Reset: hold ResetN=0, then release, then 3 OneHzEn pulses → 00:00 during reset; 00:03 after pulses; Paused=0.
- Rollover: preload to 59:58 via ADJ (minutes 59, seconds 58), return to RUN, 2 OneHzEn pulses → 59:59, then 00:00.
- Pause: in RUN at 00:05, PauseIn high for 10 cycles with 3 OneHzEn pulses during HALT → Paused=1 and display stays 00:05. Second press → Paused=0 and counting resumes at 00:06 on the next pulse.
- Adjust: AdjustIn=1, SelectIn=0, 61 TwoHzEn pulses from 00:00 → 01:00 (minutes wrapped once). SelectIn=1 and 3 pulses → 01:03. AdjustBlink toggles each pulse; no OneHzEn counts occur.
- Simultaneous: OneHzEn and PauseEdge in the same cycle in RUN at 00:07 → 00:08, then HALT. AdjustIn rising with OneHzEn in the same cycle → the count applies, then ADJ.
- Async reset mid-adjust: at 12:34 in ADJ, assert ResetN between clock edges → outputs 00:00, AdjustBlink=0 and state RUN before the next edge.
